// File: rtl/irq_pkg.sv
// Shared definitions for the four-source interrupt arbiter slice.
package irq_pkg;

  localparam int unsigned NSRC       = 4;
  localparam int unsigned PRIO_W     = 4;
  localparam int unsigned VEC_STRIDE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2
  } irq_state_t;

endpackage

// File: rtl/irq_winner4.sv
// Combinational winner select: two-level compare tree over four sources,
// lower index wins ties, winner must strictly exceed the current CPU level.
module irq_winner4
  import irq_pkg::*;
(
  input  logic [NSRC-1:0]        elig,
  input  logic [NSRC*PRIO_W-1:0] prio_cfg,
  input  logic [PRIO_W-1:0]      cur_prio,
  output logic                   win_valid,
  output logic [1:0]             win_idx
);

  logic [PRIO_W-1:0] p0, p1, p2, p3;
  logic              v01, v23, i01, i23, top_lo;
  logic [PRIO_W-1:0] pr01, pr23, win_prio;

  assign p0 = prio_cfg[0*PRIO_W +: PRIO_W];
  assign p1 = prio_cfg[1*PRIO_W +: PRIO_W];
  assign p2 = prio_cfg[2*PRIO_W +: PRIO_W];
  assign p3 = prio_cfg[3*PRIO_W +: PRIO_W];

  always_comb begin
    // Level 1: pairwise, the left (lower index) side keeps ties.
    v01  = elig[0] | elig[1];
    i01  = ~(elig[0] && (!elig[1] || p0 >= p1));
    pr01 = i01 ? p1 : p0;
    v23  = elig[2] | elig[3];
    i23  = ~(elig[2] && (!elig[3] || p2 >= p3));
    pr23 = i23 ? p3 : p2;
    // Level 2: same tie rule between the pair winners.
    top_lo   = v01 && (!v23 || pr01 >= pr23);
    win_idx  = top_lo ? {1'b0, i01} : {1'b1, i23};
    win_prio = top_lo ? pr01 : pr23;
    win_valid = (v01 | v23) && (win_prio > cur_prio);
  end

endmodule

// File: rtl/irq_arbiter.sv
// Four-source rising-edge interrupt arbiter with int_req/iack handshake.
// Optional build macro IRQ_MASK_EN adds the irq_mask input.
module irq_arbiter
  import irq_pkg::*;
#(
  parameter int unsigned       VEC_W    = 32,
  parameter logic [VEC_W-1:0]  VEC_BASE = VEC_W'(32'h0000_0100)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NSRC-1:0]        irq_in,
  input  logic [NSRC*PRIO_W-1:0] prio_cfg,
  input  logic [PRIO_W-1:0]      cur_prio,
  input  logic [NSRC-1:0]        irq_clr,
`ifdef IRQ_MASK_EN
  input  logic [NSRC-1:0]        irq_mask,
`endif
  input  logic                   iack,
  output logic                   int_req,
  output logic [1:0]             sel,
  output logic [VEC_W-1:0]       vector,
  output logic [NSRC-1:0]        pending
);

  irq_state_t        state_q;
  logic              int_req_q;
  logic [1:0]        sel_q;
  logic [VEC_W-1:0]  vector_q, vector_d;
  logic [NSRC-1:0]   irq_q, pending_q, pending_d, elig;
  logic              win_valid;
  logic [1:0]        win_idx;

  // Set beats clear when a new edge lands on the clearing cycle.
  assign pending_d = (pending_q & ~irq_clr) | (irq_in & ~irq_q);

`ifdef IRQ_MASK_EN
  assign elig = pending_q & ~irq_mask;
`else
  assign elig = pending_q;
`endif

  irq_winner4 u_winner (
    .elig      (elig),
    .prio_cfg  (prio_cfg),
    .cur_prio  (cur_prio),
    .win_valid (win_valid),
    .win_idx   (win_idx)
  );

  assign vector_d = VEC_BASE + (VEC_W'(win_idx) * VEC_W'(VEC_STRIDE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_q     <= '0;
      pending_q <= '0;
    end else begin
      irq_q     <= irq_in;
      pending_q <= pending_d;
    end
  end

  // sel/vector only move on IDLE->REQ; held through ACK for the decoder.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      int_req_q <= 1'b0;
      sel_q     <= '0;
      vector_q  <= VEC_BASE;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_valid) begin
            state_q   <= REQ;
            int_req_q <= 1'b1;
            sel_q     <= win_idx;
            vector_q  <= vector_d;
          end
        end
        REQ: begin
          if (iack) begin
            state_q   <= ACK;
            int_req_q <= 1'b0;
          end
        end
        ACK: begin
          if (!iack) state_q <= IDLE;
        end
        default: begin
          state_q   <= IDLE;
          int_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign int_req = int_req_q;
  assign sel     = sel_q;
  assign vector  = vector_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Scoreboard bench for irq_arbiter: expected grants queued by stimulus,
// popped by a monitor on every rising int_req; a one-hot decoder model drives irq_clr.
module tb_irq_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  irq_in;
  logic [15:0] prio_cfg;
  logic [3:0]  cur_prio;
  logic [3:0]  irq_clr;
  logic        iack;
  logic        int_req;
  logic [1:0]  sel;
  logic [31:0] vector;
  logic [3:0]  pending;
`ifdef IRQ_MASK_EN
  logic [3:0]  irq_mask;
`endif

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] vec;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // IACK decoder model: combinational one-hot of sel while iack is high.
  assign irq_clr = iack ? (4'b0001 << sel) : 4'b0000;

  irq_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .irq_in   (irq_in),
    .prio_cfg (prio_cfg),
    .cur_prio (cur_prio),
    .irq_clr  (irq_clr),
`ifdef IRQ_MASK_EN
    .irq_mask (irq_mask),
`endif
    .iack     (iack),
    .int_req  (int_req),
    .sel      (sel),
    .vector   (vector),
    .pending  (pending)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every new request must match the next queued grant.
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0;
      end else begin
        if (int_req && !prev) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_int_req", {31'd0, int_req}, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("grant_sel", {30'd0, sel}, {30'd0, e.sel});
            chk("grant_vector", vector, e.vec);
          end
        end
        prev = int_req;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_req(input string nm);
    int n;
    n = 0;
    while (!int_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!int_req) chk({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic do_ack();
    iack = 1'b1;
    @(negedge clk);
    iack = 1'b0;
    @(negedge clk);
  endtask

  function automatic exp_t mk(input logic [1:0] s, input logic [31:0] v);
    exp_t e;
    e.sel = s;
    e.vec = v;
    return e;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; irq_in = '0; prio_cfg = '0; cur_prio = '0; iack = 1'b0;
`ifdef IRQ_MASK_EN
    irq_mask = '0;
`endif
    cycles(2);
    chk("rst_int_req", {31'd0, int_req}, 32'd0);
    chk("rst_sel", {30'd0, sel}, 32'd0);
    chk("rst_vector", vector, 32'h100);
    chk("rst_pending", {28'd0, pending}, 32'd0);
    rst = 1'b0;
    cycles(1);

    // Single source, latency and clear via iack.
    prio_cfg = 16'h0005;
    exp_q.push_back(mk(2'd0, 32'h100));
    irq_in = 4'b0001;
    cycles(1);
    chk("t1_pending_set", {28'd0, pending}, 32'h1);
    chk("t1_no_req_yet", {31'd0, int_req}, 32'd0);
    cycles(1);
    chk("t1_req_latency", {31'd0, int_req}, 32'd1);
    iack = 1'b1;
    cycles(1);
    chk("t1_pending_clr", {28'd0, pending}, 32'h0);
    chk("t1_req_fall", {31'd0, int_req}, 32'd0);
    iack = 1'b0;
    irq_in = '0;
    cycles(2);

    // Priority: source 3 (9) over source 1 (3), then source 1.
    prio_cfg = 16'h9030;
    exp_q.push_back(mk(2'd3, 32'h10C));
    exp_q.push_back(mk(2'd1, 32'h104));
    irq_in = 4'b1010;
    wait_req("t2_first");
    do_ack();
    wait_req("t2_second");
    do_ack();
    irq_in = '0;
    cycles(1);
    chk("t2_pending_empty", {28'd0, pending}, 32'h0);

    // Tie at prio 7 blocked by cur_prio 7; lower index wins once it drops.
    prio_cfg = 16'h0770;
    cur_prio = 4'd7;
    irq_in = 4'b0110;
    cycles(5);
    chk("t3_threshold_block", {31'd0, int_req}, 32'd0);
    chk("t3_pending_held", {28'd0, pending}, 32'h6);
    exp_q.push_back(mk(2'd1, 32'h104));
    exp_q.push_back(mk(2'd2, 32'h108));
    cur_prio = 4'd6;
    wait_req("t3_first");
    do_ack();
    wait_req("t3_second");
    do_ack();
    irq_in = '0;
    cur_prio = '0;
    cycles(2);

    // No pre-emption: source 2 (F) arrives while source 0 is in REQ.
    prio_cfg = 16'h0F05;
    exp_q.push_back(mk(2'd0, 32'h100));
    exp_q.push_back(mk(2'd2, 32'h108));
    irq_in = 4'b0001;
    wait_req("t4_first");
    irq_in = 4'b0101;
    cycles(3);
    chk("t4_sel_frozen", {30'd0, sel}, 32'd0);
    chk("t4_req_held", {31'd0, int_req}, 32'd1);
    chk("t4_both_pending", {28'd0, pending}, 32'h5);
    do_ack();
    wait_req("t4_second");
    do_ack();
    irq_in = '0;
    cycles(2);

    // Set/clear collision on source 0.
    prio_cfg = 16'h0005;
    exp_q.push_back(mk(2'd0, 32'h100));
    exp_q.push_back(mk(2'd0, 32'h100));
    irq_in = 4'b0001;
    wait_req("t5_first");
    irq_in = 4'b0000;
    cycles(1);
    iack = 1'b1;
    irq_in = 4'b0001;
    cycles(1);
    chk("t5_set_wins", {28'd0, pending}, 32'h1);
    chk("t5_req_low_in_ack", {31'd0, int_req}, 32'd0);
    iack = 1'b0;
    cycles(1);
    wait_req("t5_rearb");
    do_ack();
    irq_in = '0;
    cycles(1);
    chk("t5_pending_empty", {28'd0, pending}, 32'h0);

    // Asynchronous reset while in ACK for source 1.
    prio_cfg = 16'h0050;
    exp_q.push_back(mk(2'd1, 32'h104));
    irq_in = 4'b0011;
    wait_req("t6_req");
    iack = 1'b1;
    cycles(1);
    chk("t6_ack_pending", {28'd0, pending}, 32'h1);
    chk("t6_ack_sel", {30'd0, sel}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_int_req", {31'd0, int_req}, 32'd0);
    chk("t6_rst_sel", {30'd0, sel}, 32'd0);
    chk("t6_rst_vector", vector, 32'h100);
    chk("t6_rst_pending", {28'd0, pending}, 32'h0);
    iack = 1'b0;
    irq_in = '0;
    cycles(1);
    rst = 1'b0;
    cycles(2);

`ifdef IRQ_MASK_EN
    // Masked source latches pending but waits until unmasked.
    prio_cfg = 16'h0005;
    irq_mask = 4'b0001;
    irq_in = 4'b0001;
    cycles(5);
    chk("t7_masked_pending", {28'd0, pending}, 32'h1);
    chk("t7_masked_no_req", {31'd0, int_req}, 32'd0);
    exp_q.push_back(mk(2'd0, 32'h100));
    irq_mask = 4'b0000;
    wait_req("t7_unmask");
    do_ack();
    irq_in = '0;
    cycles(2);
`endif

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/irq_arbiter.md
# irq_arbiter

Four-source interrupt arbiter that latches rising-edge requests, selects the highest-priority eligible pending source, and runs the `int_req`/`iack` handshake with the CPU. It drives the 2-bit source select consumed by the IACK decoder stage. It takes that decoder's 4-bit one-hot clear vector back to retire the serviced pending bit.

## Interface
Parameters:
- `VEC_W`, default 32: vector output width.
- `VEC_BASE`, default 32'h0000_0100: vector table base address.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset; asynchronous, active-high.
- `irq_in`, in, 4: raw source requests, rising-edge sensitive.
- `prio_cfg`, in, 16: per-source priority; `[4i+3:4i]` belongs to source i.
- `cur_prio`, in, 4: current CPU priority level.
- `irq_clr`, in, 4: one-hot clear vector from the IACK decoder.
- `iack`, in, 1: CPU interrupt acknowledge, level.
- `int_req`, out, 1: interrupt request to the CPU.
- `sel`, out, 2: granted source index; drives the decoder's priority select.
- `vector`, out, VEC_W: handler address, equal to `VEC_BASE + {sel, 2'b00}`.
- `pending`, out, 4: pending flags.

## Operation
- Edge detect:
  - `irq_q` holds `irq_in` registered.
  - `pending[i]` is set when `irq_in[i] & ~irq_q[i]`.
  - `pending[i]` is cleared when `irq_clr[i]`.
  - If set and clear occur in the same cycle, set wins.
- Eligibility: a source is eligible when `pending[i]`. With `IRQ_MASK_EN` defined, it must also satisfy `~irq_mask[i]`.
- Winner selection:
  - The eligible source with the largest `prio_cfg` field wins; comparison is unsigned 4-bit.
  - On equal priority, the lower index wins.
  - The winner is valid only when its priority is strictly greater than `cur_prio`.
- State machine: IDLE → REQ → ACK → IDLE.
  - IDLE: `int_req` = 0. If a winner is valid, latch `sel` and `vector` and go to REQ.
  - REQ: `int_req` = 1. `sel` and `vector` are frozen, with no pre-emption, even if a higher-priority source arrives or `cur_prio` changes. On `iack` = 1, go to ACK.
  - ACK: `int_req` = 0. `sel` is held so the decoder's `irq_clr` stays aligned. On `iack` = 0, go to IDLE.
- The arbiter never clears `pending` itself. Clearing comes only through `irq_clr`.
- Reset values: state IDLE, `int_req` 0, `sel` 0, `vector` = `VEC_BASE`, `pending` 0, `irq_q` 0.
- Reset mid-handshake: return to IDLE at once and drop all pending flags.

## Timing
- `irq_in[i]` first sampled high at edge N: `pending[i]` = 1 after N.
- Earliest `int_req` is after edge N+1, giving 2-cycle request latency.
- `sel` and `vector` change only on the IDLE→REQ transition. They are valid in the same cycle `int_req` rises.
- `iack` sampled high at edge M:
  - `irq_clr` (combinational in the decoder) clears `pending[sel]` at edge M.
  - State is ACK after M; `int_req` is low after M.
- `iack` sampled low at edge K: IDLE after K. The next `int_req` comes no earlier than after K+1.
- `iack` asserted while in IDLE is ignored.
- `irq_clr` for a non-granted source clears that bit in any state.

## Configuration
- `IRQ_MASK_EN` defined:
  - Adds input `irq_mask`, 4 bits.
  - Masked sources still latch `pending` but are excluded from arbitration.
  - Unmasking a pending source makes it eligible on the next IDLE evaluation.
- Not defined: the port is absent and all pending sources are eligible.

## Structure
- Shared package `irq_pkg` holds:
  - `NSRC` = 4 and `PRIO_W` = 4.
  - State enum typedef `irq_state_t` (IDLE, REQ, ACK).
  - `VEC_STRIDE` = 4.
- Sub-module `irq_winner4` is combinational. It takes the eligible mask, `prio_cfg` and `cur_prio`, and returns `win_valid` and `win_idx[1:0]`. It is built as a two-level compare tree with a lower-index tie-break.

## Test plan
- Single source:
  - Stimulus: `prio_cfg` = 16'h0005, `cur_prio` = 0, pulse `irq_in[0]`.
  - Response: `int_req` high two cycles later, `sel` = 0, `vector` = 32'h100. `iack` clears `pending[0]` and `int_req` falls after the `iack` edge.
- Priority:
  - Stimulus: `irq_in[1]` (prio 3) and `irq_in[3]` (prio 9) rise together.
  - Response: `sel` = 3, `vector` = 32'h10C. After the handshake, `sel` = 1 is granted.
- Tie and threshold:
  - Stimulus: sources 1 and 2 both at prio 7 with `cur_prio` = 7, then `cur_prio` = 6.
  - Response: no `int_req` while `cur_prio` = 7. After it drops to 6, `sel` = 1.
- No pre-emption:
  - Stimulus: source 2 (prio F) rises while in REQ for source 0.
  - Response: `sel` stays 0 until ACK completes, then source 2 is granted.
- Set/clear collision:
  - Stimulus: a new `irq_in[0]` edge in the same cycle as `irq_clr[0]`.
  - Response: `pending[0]` remains 1 and is re-arbitrated.
- Reset and mask:
  - Stimulus: `rst` asserted in ACK.
  - Response: all outputs go to reset values. With `IRQ_MASK_EN` and `irq_mask` = 4'b0001, source 0 stays pending and unserviced until unmasked.
